// File: rtl/pipe_adder_array.sv
// Multi-lane pipelined add/sub/accumulate; STAGES-cycle latency, 1 beat/cycle, valid/ready with combinational ready chain.
// Optional ADDER_SAT_EN macro selects saturating arithmetic instead of modulo wrap.
module pipe_adder_array #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 2,
   parameter int STAGES   = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [1:0]                in_mode,
   input  logic [CHANNELS*WIDTH-1:0] in_a,
   input  logic [CHANNELS*WIDTH-1:0] in_b,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [CHANNELS*WIDTH-1:0] out_sum,
   output logic [CHANNELS-1:0]       out_carry
);

   localparam logic [1:0] MODE_ADD = 2'b00;
   localparam logic [1:0] MODE_SUB = 2'b01;
   localparam logic [1:0] MODE_ACC = 2'b10;
   localparam int         CW       = CHANNELS * WIDTH;

   logic [STAGES-1:0] v_q, v_d;
   logic [CW-1:0]       sum_q   [STAGES];
   logic [CW-1:0]       sum_d   [STAGES];
   logic [CHANNELS-1:0] carry_q [STAGES];
   logic [CHANNELS-1:0] carry_d [STAGES];
   logic [WIDTH-1:0]    acc_q   [CHANNELS];
   logic [WIDTH-1:0]    acc_d   [CHANNELS];

   logic [STAGES:0]     ld;
   logic                accept;
   logic [CW-1:0]       res_sum;
   logic [CHANNELS-1:0] res_carry;

   // Returns {carry/borrow, result} for one lane.
   function automatic logic [WIDTH:0] lane_op(input logic [1:0]       mode,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [WIDTH-1:0] acc);
      logic [WIDTH:0] t;
      logic [WIDTH:0] r;
      t = '0;
      r = '0;
      case (mode)
         MODE_ADD, MODE_ACC: begin
            t = (mode == MODE_ADD) ? ({1'b0, a} + {1'b0, b}) : ({1'b0, acc} + {1'b0, a});
            r = t;
`ifdef ADDER_SAT_EN
            if (t[WIDTH]) r[WIDTH-1:0] = '1;
`endif
         end
         MODE_SUB: begin
            t = {1'b0, a} - {1'b0, b};
            r = t;
`ifdef ADDER_SAT_EN
            if (t[WIDTH]) r[WIDTH-1:0] = '0;
`endif
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   // Ready chain: a stage can load when empty or when everything downstream drains this cycle.
   always_comb begin
      ld         = '0;
      ld[STAGES] = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         ld[k] = !v_q[k] || ld[k+1];
      end
   end

   assign in_ready = ld[0];
   assign accept   = in_valid && ld[0];

   always_comb begin
      logic [WIDTH:0] r;
      res_sum   = '0;
      res_carry = '0;
      r         = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         acc_d[i] = acc_q[i];
         r = lane_op(in_mode, in_a[i*WIDTH +: WIDTH], in_b[i*WIDTH +: WIDTH], acc_q[i]);
         res_sum[i*WIDTH +: WIDTH] = r[WIDTH-1:0];
         res_carry[i]              = r[WIDTH];
         if (accept && in_mode[1]) acc_d[i] = r[WIDTH-1:0];
      end
   end

   always_comb begin
      v_d[0]     = ld[0] ? in_valid : v_q[0];
      sum_d[0]   = accept ? res_sum : sum_q[0];
      carry_d[0] = accept ? res_carry : carry_q[0];
      for (int k = 1; k < STAGES; k++) begin
         v_d[k]     = ld[k] ? v_q[k-1] : v_q[k];
         sum_d[k]   = (ld[k] && v_q[k-1]) ? sum_q[k-1] : sum_q[k];
         carry_d[k] = (ld[k] && v_q[k-1]) ? carry_q[k-1] : carry_q[k];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            sum_q[k]   <= '0;
            carry_q[k] <= '0;
         end
         for (int i = 0; i < CHANNELS; i++) acc_q[i] <= '0;
      end else begin
         v_q <= v_d;
         for (int k = 0; k < STAGES; k++) begin
            sum_q[k]   <= sum_d[k];
            carry_q[k] <= carry_d[k];
         end
         for (int i = 0; i < CHANNELS; i++) acc_q[i] <= acc_d[i];
      end
   end

   assign out_valid = v_q[STAGES-1];
   assign out_sum   = sum_q[STAGES-1];
   assign out_carry = carry_q[STAGES-1];

endmodule

// File: tb/tb_pipe_adder_array.sv
// Scoreboard bench for pipe_adder_array: expected beats are queued at input acceptance and compared at output acceptance.
module tb_pipe_adder_array;
   localparam int W  = 8;
   localparam int C  = 2;
   localparam int S  = 2;
   localparam int CW = W * C;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [1:0]    in_mode = 2'b00;
   logic [CW-1:0] in_a = '0;
   logic [CW-1:0] in_b = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [CW-1:0] out_sum;
   logic [C-1:0]  out_carry;

   int checks = 0;
   int errors = 0;
   int n_sent = 0;

   logic [CW-1:0] exp_sum_q   [$];
   logic [C-1:0]  exp_carry_q [$];

   logic          hold_vld = 1'b0;
   logic [CW-1:0] hold_sum;
   logic [C-1:0]  hold_carry;

   pipe_adder_array #(.WIDTH(W), .CHANNELS(C), .STAGES(S)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mode   (in_mode),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_carry (out_carry)
   );

   always #5 clk = ~clk;

   // Output monitor: transfers happen on the following rising edge.
   always @(negedge clk) begin
      if (rst && out_valid) begin
         if (!out_ready) begin
            if (hold_vld) begin
               checks++;
               if (out_sum !== hold_sum || out_carry !== hold_carry) begin
                  errors++;
                  $display("FAIL stall_stable got sum=%h carry=%b want sum=%h carry=%b",
                           out_sum, out_carry, hold_sum, hold_carry);
               end
            end
            hold_vld   = 1'b1;
            hold_sum   = out_sum;
            hold_carry = out_carry;
         end else begin
            hold_vld = 1'b0;
            checks++;
            if (exp_sum_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_output got sum=%h want no beat", out_sum);
            end else begin
               logic [CW-1:0] es;
               logic [C-1:0]  ec;
               es = exp_sum_q.pop_front();
               ec = exp_carry_q.pop_front();
               if (out_sum !== es) begin
                  errors++;
                  $display("FAIL out_sum got %h want %h", out_sum, es);
               end
               checks++;
               if (out_carry !== ec) begin
                  errors++;
                  $display("FAIL out_carry got %b want %b", out_carry, ec);
               end
            end
         end
      end else begin
         hold_vld = 1'b0;
      end
   end

   task automatic send(input logic [1:0] m, input logic [CW-1:0] a, input logic [CW-1:0] b,
                       input logic [CW-1:0] es, input logic [C-1:0] ec);
      int t;
      t        = 0;
      in_valid = 1'b1;
      in_mode  = m;
      in_a     = a;
      in_b     = b;
      @(negedge clk);
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout got in_ready=0 want 1");
      end else begin
         exp_sum_q.push_back(es);
         exp_carry_q.push_back(ec);
         n_sent++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Called right after send returns (1ns past the accepting edge).
   task automatic check_latency(input string name);
      int lat;
      lat = 1;
      while (!out_valid && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checks++;
      if (lat !== S) begin
         errors++;
         $display("FAIL %s_latency got %0d want %0d", name, lat, S);
      end
   endtask

   task automatic wait_drain(input string name);
      int t;
      t = 0;
      while (exp_sum_q.size() != 0 && t < 100) begin
         @(posedge clk);
         t++;
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (exp_sum_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain got %0d pending want 0", name, exp_sum_q.size());
      end
   endtask

   function automatic void model(input logic [1:0] m, input logic [CW-1:0] a, input logic [CW-1:0] b,
                                 output logic [CW-1:0] s, output logic [C-1:0] c);
      int x, y, r;
      s = '0;
      c = '0;
      for (int i = 0; i < C; i++) begin
         x = int'(a[i*W +: W]);
         y = int'(b[i*W +: W]);
         if (m == 2'b00) begin
            r    = x + y;
            c[i] = (r >= 2**W);
`ifdef ADDER_SAT_EN
            if (c[i]) r = 2**W - 1;
`endif
         end else begin
            c[i] = (x < y);
            r    = c[i] ? x - y + 2**W : x - y;
`ifdef ADDER_SAT_EN
            if (c[i]) r = 0;
`endif
         end
         s[i*W +: W] = r[W-1:0];
      end
   endfunction

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_out_valid got %b want 0", out_valid);
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready got %b want 1", in_ready);
      end
   endtask

   task automatic test_add();
`ifdef ADDER_SAT_EN
      send(2'b00, {8'd200, 8'd6}, {8'd100, 8'd3}, {8'd255, 8'd9}, 2'b10);
`else
      send(2'b00, {8'd200, 8'd6}, {8'd100, 8'd3}, {8'd44, 8'd9}, 2'b10);
`endif
      check_latency("add");
      wait_drain("add");
   endtask

   task automatic test_sub();
`ifdef ADDER_SAT_EN
      send(2'b01, {8'd9, 8'd3}, {8'd4, 8'd6}, {8'd5, 8'd0}, 2'b01);
`else
      send(2'b01, {8'd9, 8'd3}, {8'd4, 8'd6}, {8'd5, 8'd253}, 2'b01);
`endif
      wait_drain("sub");
   endtask

   task automatic test_acc();
      send(2'b11, {8'd77, 8'd77}, {8'd1, 8'd1}, {8'd0, 8'd0}, 2'b00);
      send(2'b10, {8'd1, 8'd10}, '0, {8'd1, 8'd10}, 2'b00);
      send(2'b10, {8'd1, 8'd10}, '0, {8'd2, 8'd20}, 2'b00);
      send(2'b10, {8'd1, 8'd10}, '0, {8'd3, 8'd30}, 2'b00);
`ifdef ADDER_SAT_EN
      send(2'b10, {8'd1, 8'd250}, '0, {8'd4, 8'd255}, 2'b01);
      send(2'b10, {8'd1, 8'd0}, '0, {8'd5, 8'd255}, 2'b00);
`else
      send(2'b10, {8'd1, 8'd250}, '0, {8'd4, 8'd24}, 2'b01);
      send(2'b10, {8'd1, 8'd0}, '0, {8'd5, 8'd24}, 2'b00);
`endif
      wait_drain("acc");
   endtask

   task automatic test_back_to_back();
      n_sent = 0;
      fork
         begin
            for (int n = 0; n < 8; n++) begin
               logic [1:0]    m;
               logic [CW-1:0] a, b, es;
               logic [C-1:0]  ec;
               m = 2'($urandom_range(0, 1));
               a = CW'($urandom);
               b = CW'($urandom);
               model(m, a, b, es, ec);
               send(m, a, b, es, ec);
            end
         end
         begin
            int t;
            t = 0;
            while (n_sent < 2 && t < 200) begin
               @(posedge clk);
               t++;
            end
            #1;
            out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("FAIL stall_in_ready got %b want 0", in_ready);
            end
            out_ready = 1'b1;
         end
      join
      wait_drain("stream");
   endtask

   task automatic test_reset_mid();
      send(2'b10, {8'd3, 8'd4}, '0, {8'd3, 8'd4}, 2'b00);
      send(2'b10, {8'd3, 8'd4}, '0, {8'd6, 8'd8}, 2'b00);
      rst = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL midreset_out_valid got %b want 0", out_valid);
      end
      exp_sum_q.delete();
      exp_carry_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL midreset_idle got out_valid=%b want 0", out_valid);
      end
      send(2'b10, {8'd5, 8'd7}, '0, {8'd5, 8'd7}, 2'b00);
      check_latency("midreset");
      wait_drain("midreset");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_acc();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
